conv_seq_ctrl: RTL and testbench
================================

CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 Parameter NUM_FILT, default 4, number of filters processed per start; legal range 1..255.
REQ-002 Parameter MEM_ACK_EN, default 0; 1 = every memory write waits for mem_ack.
REQ-003 Parameter FI_W, default $clog2(NUM_FILT+1), width of filt_idx.
REQ-004 Clocking: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  pulse/level; sampled only in IDLE.
REQ-008 adr_ready, filt_full, temp_full, temp_empty, calc_done, wr_full, adr_last, mem_ack  in  1 each  datapath status.
REQ-009 ld_adr, rst_x, rst_wr, ld_wr, we_mem, re_mem, rst_calc, en_calc, we_view, re_view, we_filt, re_filt, we_temp, re_temp, rst_temp, rst_filt, last_wr  out  1 each  datapath strobes.
REQ-010 sel  out  2  memory address source: 00 input, 01 filter, 10 result, 11 idle.
REQ-011 filt_idx  out  FI_W  index of filter in progress.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle pulse after the last filter's final write.

Function
REQ-014 Moore FSM; all strobes SHALL be decoded from state only; each defaults to 0, sel defaults to 11.
REQ-015 IDLE: start=1 -> INIT, else stay.
REQ-016 INIT: rst_calc, rst_temp, rst_wr, ld_adr = 1; -> WAIT_ADR.
REQ-017 WAIT_ADR: adr_ready -> LD_FILT.
REQ-018 LD_FILT: we_filt, re_mem = 1, sel=01; filt_full -> RST_X.
REQ-019 RST_X: rst_x = 1, sel=00; -> LD_TEMP.
REQ-020 LD_TEMP: we_temp, re_mem = 1, sel=00; temp_full -> SHIFT.
REQ-021 SHIFT: re_temp, rst_calc = 1; -> VIEW.
REQ-022 VIEW: we_view, rst_filt = 1; -> CALC.
REQ-023 CALC: en_calc, re_view, re_filt = 1; calc_done -> CHECK.
REQ-024 CHECK: adr_last -> LAST_LD, else -> LD_WR.
REQ-025 LD_WR: ld_wr = 1; -> WR_CHK; WR_CHK: wr_full -> WR_SEL, else -> NEXT_WIN.
REQ-026 WR_SEL: sel=10; -> WR_MEM; WR_MEM: we_mem = 1, sel=10; -> RST_WR (MEM_ACK_EN=0) or hold until mem_ack (MEM_ACK_EN=1).
REQ-027 RST_WR: rst_wr = 1; -> NEXT_WIN. NEXT_WIN: temp_empty -> REFILL, else -> SHIFT.
REQ-028 REFILL: rst_temp = 1; -> RST_X.
REQ-029 LAST_LD: ld_wr, last_wr = 1; -> LAST_CALC; LAST_CALC: rst_calc = 1; wr_full -> LAST_SEL, else -> LAST_LD (zero padding).
REQ-030 LAST_SEL: sel=10; -> LAST_MEM; LAST_MEM: we_mem = 1, sel=10; ack rule as REQ-026; -> NEXT_FILT.
REQ-031 NEXT_FILT: filt_idx == NUM_FILT-1 -> DONE; else filt_idx increments, -> INIT.
REQ-032 DONE: done = 1; -> IDLE; filt_idx cleared on the same edge.
REQ-033 filt_idx SHALL be 0 from IDLE through the first filter and never exceed NUM_FILT-1.
REQ-034 start asserted while busy SHALL be ignored; no re-queue.
REQ-035 calc_done and adr_last simultaneously in CALC: CHECK ordering applies (flush path).
REQ-036 mem_ack outside WR_MEM/LAST_MEM SHALL be ignored; with MEM_ACK_EN=0 mem_ack is don't-care.
REQ-037 NUM_FILT=1: NEXT_FILT goes straight to DONE.

Reset
REQ-038 rst=1 SHALL force IDLE, filt_idx=0, all strobes 0, sel=11, busy=0, done=0 on the next edge, from any state including mid-write.

Structure
REQ-039 State encoding and sel codes SHALL live in shared package cnn_ctrl_pkg.
REQ-040 filt_idx counter SHALL be a sub-module filt_counter (clear, inc, terminal flag).

Verification
REQ-041 NUM_FILT=1, one window, adr_last on first CHECK: start -> INIT..LAST_MEM, done pulses once, busy drops next cycle.
REQ-042 NUM_FILT=3: filt_idx 0,1,2 observed at LD_FILT; exactly 3 INIT visits; one done.
REQ-043 wr_full after 2nd LD_WR: we_mem one cycle with sel=10, followed by rst_wr.
REQ-044 MEM_ACK_EN=1, mem_ack delayed 5 cycles: we_mem held 6 cycles, no state advance before ack.
REQ-045 rst asserted in CALC with filt_idx=2: next cycle IDLE, filt_idx=0, all strobes 0.
REQ-046 start held high through run: only one run; after DONE, new run starts from IDLE.

Source files
------------

// File: rtl/cnn_ctrl_pkg.sv
// Shared definitions for the convolution sequencer: state codes,
// memory address select codes and the datapath strobe bundle.
package cnn_ctrl_pkg;

    localparam logic [4:0] S_IDLE      = 5'd0;
    localparam logic [4:0] S_INIT      = 5'd1;
    localparam logic [4:0] S_WAIT_ADR  = 5'd2;
    localparam logic [4:0] S_LD_FILT   = 5'd3;
    localparam logic [4:0] S_RST_X     = 5'd4;
    localparam logic [4:0] S_LD_TEMP   = 5'd5;
    localparam logic [4:0] S_SHIFT     = 5'd6;
    localparam logic [4:0] S_VIEW      = 5'd7;
    localparam logic [4:0] S_CALC      = 5'd8;
    localparam logic [4:0] S_CHECK     = 5'd9;
    localparam logic [4:0] S_LD_WR     = 5'd10;
    localparam logic [4:0] S_WR_CHK    = 5'd11;
    localparam logic [4:0] S_WR_SEL    = 5'd12;
    localparam logic [4:0] S_WR_MEM    = 5'd13;
    localparam logic [4:0] S_RST_WR    = 5'd14;
    localparam logic [4:0] S_NEXT_WIN  = 5'd15;
    localparam logic [4:0] S_REFILL    = 5'd16;
    localparam logic [4:0] S_LAST_LD   = 5'd17;
    localparam logic [4:0] S_LAST_CALC = 5'd18;
    localparam logic [4:0] S_LAST_SEL  = 5'd19;
    localparam logic [4:0] S_LAST_MEM  = 5'd20;
    localparam logic [4:0] S_NEXT_FILT = 5'd21;
    localparam logic [4:0] S_DONE      = 5'd22;

    localparam logic [1:0] SEL_IN   = 2'b00;
    localparam logic [1:0] SEL_FILT = 2'b01;
    localparam logic [1:0] SEL_RES  = 2'b10;
    localparam logic [1:0] SEL_IDLE = 2'b11;

    typedef struct packed {
        logic ldAdr;
        logic rstX;
        logic rstWr;
        logic ldWr;
        logic weMem;
        logic reMem;
        logic rstCalc;
        logic enCalc;
        logic weView;
        logic reView;
        logic weFilt;
        logic reFilt;
        logic weTemp;
        logic reTemp;
        logic rstTemp;
        logic rstFilt;
        logic lastWr;
    } ctrl_t;

endpackage

// File: rtl/filt_counter.sv
// Filter index counter: clears, increments and flags the final filter.
// Increment saturates on the final filter so the index never overruns.
module filt_counter #(
    parameter int NUM = 4,
    parameter int W   = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         last
);

    assign last = (cnt == W'(NUM - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && !last) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Convolution sequencer: Moore FSM walking filter load, window
// compute and result write-back for NUM_FILT filters per start.
module conv_seq_ctrl
    import cnn_ctrl_pkg::*;
#(
    parameter int NUM_FILT   = 4,
    parameter bit MEM_ACK_EN = 1'b0,
    parameter int FI_W       = $clog2(NUM_FILT + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            adr_ready,
    input  logic            filt_full,
    input  logic            temp_full,
    input  logic            temp_empty,
    input  logic            calc_done,
    input  logic            wr_full,
    input  logic            adr_last,
    input  logic            mem_ack,
    output logic            ld_adr,
    output logic            rst_x,
    output logic            rst_wr,
    output logic            ld_wr,
    output logic            we_mem,
    output logic            re_mem,
    output logic            rst_calc,
    output logic            en_calc,
    output logic            we_view,
    output logic            re_view,
    output logic            we_filt,
    output logic            re_filt,
    output logic            we_temp,
    output logic            re_temp,
    output logic            rst_temp,
    output logic            rst_filt,
    output logic            last_wr,
    output logic [1:0]      sel,
    output logic [FI_W-1:0] filt_idx,
    output logic            busy,
    output logic            done
);

    logic [4:0] state;
    logic [4:0] nxt;
    logic       memGo;
    logic       lastFilt;
    ctrl_t      ctl;
    logic [1:0] selQ;

    // Without handshaking a memory write always completes in one cycle.
    assign memGo = !MEM_ACK_EN || mem_ack;

    filt_counter #(
        .NUM (NUM_FILT),
        .W   (FI_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == S_DONE),
        .inc  (state == S_NEXT_FILT),
        .cnt  (filt_idx),
        .last (lastFilt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:      nxt = start ? S_INIT : S_IDLE;
            S_INIT:      nxt = S_WAIT_ADR;
            S_WAIT_ADR:  nxt = adr_ready ? S_LD_FILT : S_WAIT_ADR;
            S_LD_FILT:   nxt = filt_full ? S_RST_X : S_LD_FILT;
            S_RST_X:     nxt = S_LD_TEMP;
            S_LD_TEMP:   nxt = temp_full ? S_SHIFT : S_LD_TEMP;
            S_SHIFT:     nxt = S_VIEW;
            S_VIEW:      nxt = S_CALC;
            S_CALC:      nxt = calc_done ? S_CHECK : S_CALC;
            S_CHECK:     nxt = adr_last ? S_LAST_LD : S_LD_WR;
            S_LD_WR:     nxt = S_WR_CHK;
            S_WR_CHK:    nxt = wr_full ? S_WR_SEL : S_NEXT_WIN;
            S_WR_SEL:    nxt = S_WR_MEM;
            S_WR_MEM:    nxt = memGo ? S_RST_WR : S_WR_MEM;
            S_RST_WR:    nxt = S_NEXT_WIN;
            S_NEXT_WIN:  nxt = temp_empty ? S_REFILL : S_SHIFT;
            S_REFILL:    nxt = S_RST_X;
            S_LAST_LD:   nxt = S_LAST_CALC;
            S_LAST_CALC: nxt = wr_full ? S_LAST_SEL : S_LAST_LD;
            S_LAST_SEL:  nxt = S_LAST_MEM;
            S_LAST_MEM:  nxt = memGo ? S_NEXT_FILT : S_LAST_MEM;
            S_NEXT_FILT: nxt = lastFilt ? S_DONE : S_INIT;
            S_DONE:      nxt = S_IDLE;
            default:     nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ctl  = '0;
        selQ = SEL_IDLE;
        unique case (state)
            S_INIT: begin
                ctl.rstCalc = 1'b1;
                ctl.rstTemp = 1'b1;
                ctl.rstWr   = 1'b1;
                ctl.ldAdr   = 1'b1;
            end
            S_LD_FILT: begin
                ctl.weFilt = 1'b1;
                ctl.reMem  = 1'b1;
                selQ       = SEL_FILT;
            end
            S_RST_X: begin
                ctl.rstX = 1'b1;
                selQ     = SEL_IN;
            end
            S_LD_TEMP: begin
                ctl.weTemp = 1'b1;
                ctl.reMem  = 1'b1;
                selQ       = SEL_IN;
            end
            S_SHIFT: begin
                ctl.reTemp  = 1'b1;
                ctl.rstCalc = 1'b1;
            end
            S_VIEW: begin
                ctl.weView  = 1'b1;
                ctl.rstFilt = 1'b1;
            end
            S_CALC: begin
                ctl.enCalc = 1'b1;
                ctl.reView = 1'b1;
                ctl.reFilt = 1'b1;
            end
            S_LD_WR:     ctl.ldWr = 1'b1;
            S_WR_SEL:    selQ = SEL_RES;
            S_WR_MEM: begin
                ctl.weMem = 1'b1;
                selQ      = SEL_RES;
            end
            S_RST_WR:    ctl.rstWr = 1'b1;
            S_REFILL:    ctl.rstTemp = 1'b1;
            S_LAST_LD: begin
                ctl.ldWr   = 1'b1;
                ctl.lastWr = 1'b1;
            end
            S_LAST_CALC: ctl.rstCalc = 1'b1;
            S_LAST_SEL:  selQ = SEL_RES;
            S_LAST_MEM: begin
                ctl.weMem = 1'b1;
                selQ      = SEL_RES;
            end
            default: ;
        endcase
    end

    assign ld_adr   = ctl.ldAdr;
    assign rst_x    = ctl.rstX;
    assign rst_wr   = ctl.rstWr;
    assign ld_wr    = ctl.ldWr;
    assign we_mem   = ctl.weMem;
    assign re_mem   = ctl.reMem;
    assign rst_calc = ctl.rstCalc;
    assign en_calc  = ctl.enCalc;
    assign we_view  = ctl.weView;
    assign re_view  = ctl.reView;
    assign we_filt  = ctl.weFilt;
    assign re_filt  = ctl.reFilt;
    assign we_temp  = ctl.weTemp;
    assign re_temp  = ctl.reTemp;
    assign rst_temp = ctl.rstTemp;
    assign rst_filt = ctl.rstFilt;
    assign last_wr  = ctl.lastWr;
    assign sel      = selQ;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: two instances (1 filter no-ack, 3 filters
// with ack) against a cycle scoreboard plus run-level checks.
module tb_conv_seq_ctrl;

    typedef enum int {
        IDLE, INIT, WAIT_ADR, LD_FILT, RST_X, LD_TEMP, SHIFT, VIEW,
        CALC, CHECK, LD_WR, WR_CHK, WR_SEL, WR_MEM, RST_WR, NEXT_WIN,
        REFILL, LAST_LD, LAST_CALC, LAST_SEL, LAST_MEM, NEXT_FILT, DONE
    } stT;

    typedef struct packed {
        logic ldAdr, rstX, rstWr, ldWr, weMem, reMem, rstCalc, enCalc;
        logic weView, reView, weFilt, reFilt, weTemp, reTemp, rstTemp;
        logic rstFilt, lastWr;
        logic [1:0] sel;
        logic busy, done;
    } outT;

    typedef struct {
        logic [20:0] o;
        int          fi;
    } expT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, adr_ready, filt_full, temp_full, temp_empty;
    logic calc_done, wr_full, adr_last, mem_ack;

    wire [16:0] stA, stB;
    wire [1:0]  selA, selB;
    wire        busyA, busyB, doneA, doneB;
    wire [0:0]  fiA;
    wire [1:0]  fiB;

    conv_seq_ctrl #(.NUM_FILT(1), .MEM_ACK_EN(1'b0)) dutA (
        .clk(clk), .rst(rst), .start(start), .adr_ready(adr_ready),
        .filt_full(filt_full), .temp_full(temp_full),
        .temp_empty(temp_empty), .calc_done(calc_done),
        .wr_full(wr_full), .adr_last(adr_last), .mem_ack(mem_ack),
        .ld_adr(stA[16]), .rst_x(stA[15]), .rst_wr(stA[14]),
        .ld_wr(stA[13]), .we_mem(stA[12]), .re_mem(stA[11]),
        .rst_calc(stA[10]), .en_calc(stA[9]), .we_view(stA[8]),
        .re_view(stA[7]), .we_filt(stA[6]), .re_filt(stA[5]),
        .we_temp(stA[4]), .re_temp(stA[3]), .rst_temp(stA[2]),
        .rst_filt(stA[1]), .last_wr(stA[0]), .sel(selA),
        .filt_idx(fiA), .busy(busyA), .done(doneA)
    );

    conv_seq_ctrl #(.NUM_FILT(3), .MEM_ACK_EN(1'b1)) dutB (
        .clk(clk), .rst(rst), .start(start), .adr_ready(adr_ready),
        .filt_full(filt_full), .temp_full(temp_full),
        .temp_empty(temp_empty), .calc_done(calc_done),
        .wr_full(wr_full), .adr_last(adr_last), .mem_ack(mem_ack),
        .ld_adr(stB[16]), .rst_x(stB[15]), .rst_wr(stB[14]),
        .ld_wr(stB[13]), .we_mem(stB[12]), .re_mem(stB[11]),
        .rst_calc(stB[10]), .en_calc(stB[9]), .we_view(stB[8]),
        .re_view(stB[7]), .we_filt(stB[6]), .re_filt(stB[5]),
        .we_temp(stB[4]), .re_temp(stB[3]), .rst_temp(stB[2]),
        .rst_filt(stB[1]), .last_wr(stB[0]), .sel(selB),
        .filt_idx(fiB), .busy(busyB), .done(doneB)
    );

    int total = 0;
    int bad = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic outT expOut(stT s);
        outT o;
        o      = '0;
        o.sel  = 2'b11;
        o.busy = (s != IDLE);
        case (s)
            INIT:      begin o.ldAdr = 1; o.rstCalc = 1; o.rstTemp = 1;
                             o.rstWr = 1; end
            LD_FILT:   begin o.weFilt = 1; o.reMem = 1; o.sel = 2'b01; end
            RST_X:     begin o.rstX = 1; o.sel = 2'b00; end
            LD_TEMP:   begin o.weTemp = 1; o.reMem = 1; o.sel = 2'b00; end
            SHIFT:     begin o.reTemp = 1; o.rstCalc = 1; end
            VIEW:      begin o.weView = 1; o.rstFilt = 1; end
            CALC:      begin o.enCalc = 1; o.reView = 1; o.reFilt = 1; end
            LD_WR:     o.ldWr = 1;
            WR_SEL:    o.sel = 2'b10;
            WR_MEM:    begin o.weMem = 1; o.sel = 2'b10; end
            RST_WR:    o.rstWr = 1;
            REFILL:    o.rstTemp = 1;
            LAST_LD:   begin o.ldWr = 1; o.lastWr = 1; end
            LAST_CALC: o.rstCalc = 1;
            LAST_SEL:  o.sel = 2'b10;
            LAST_MEM:  begin o.weMem = 1; o.sel = 2'b10; end
            DONE:      o.done = 1;
            default:   ;
        endcase
        return o;
    endfunction

    function automatic stT nextSt(stT s, bit lastF, bit ackEn);
        bit go;
        go = !ackEn || (mem_ack === 1'b1);
        case (s)
            IDLE:      return start ? INIT : IDLE;
            INIT:      return WAIT_ADR;
            WAIT_ADR:  return adr_ready ? LD_FILT : WAIT_ADR;
            LD_FILT:   return filt_full ? RST_X : LD_FILT;
            RST_X:     return LD_TEMP;
            LD_TEMP:   return temp_full ? SHIFT : LD_TEMP;
            SHIFT:     return VIEW;
            VIEW:      return CALC;
            CALC:      return calc_done ? CHECK : CALC;
            CHECK:     return adr_last ? LAST_LD : LD_WR;
            LD_WR:     return WR_CHK;
            WR_CHK:    return wr_full ? WR_SEL : NEXT_WIN;
            WR_SEL:    return WR_MEM;
            WR_MEM:    return go ? RST_WR : WR_MEM;
            RST_WR:    return NEXT_WIN;
            NEXT_WIN:  return temp_empty ? REFILL : SHIFT;
            REFILL:    return RST_X;
            LAST_LD:   return LAST_CALC;
            LAST_CALC: return wr_full ? LAST_SEL : LAST_LD;
            LAST_SEL:  return LAST_MEM;
            LAST_MEM:  return go ? NEXT_FILT : LAST_MEM;
            NEXT_FILT: return lastF ? DONE : INIT;
            default:   return IDLE;
        endcase
    endfunction

    function automatic bit inMem(stT s);
        return (s == WR_MEM) || (s == LAST_MEM);
    endfunction

    expT qA[$];
    expT qB[$];
    stT  mA, mB;
    int  fiMA, fiMB;
    int  runA, runB, initA, initB, doneCntA, doneCntB, ackWait;
    bit  didRst;

    initial begin
        expT e;
        rst = 1; start = 0; adr_ready = 0; filt_full = 0; temp_full = 0;
        temp_empty = 0; calc_done = 0; wr_full = 0; adr_last = 0;
        mem_ack = 0;
        mA = IDLE; mB = IDLE; fiMA = 0; fiMB = 0;
        runA = 0; runB = 0; initA = 0; initB = 0;
        doneCntA = 0; doneCntB = 0; ackWait = 0; didRst = 0;

        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(negedge clk);
            if (qA.size() > 0) begin
                e = qA.pop_front();
                check("A out", 32'({stA, selA, busyA, doneA}), 32'(e.o));
                check("A fi", 32'(fiA), 32'(e.fi));
            end
            if (qB.size() > 0) begin
                e = qB.pop_front();
                check("B out", 32'({stB, selB, busyB, doneB}), 32'(e.o));
                check("B fi", 32'(fiB), 32'(e.fi));
            end

            // run-level properties taken straight from DUT outputs
            if (stA[12] === 1'b1) runA++;
            else if (runA > 0) begin
                check("A weMem len", 32'(runA), 32'd1);
                runA = 0;
            end
            if (stB[12] === 1'b1) runB++;
            else if (runB > 0) begin
                check("B weMem len", 32'(runB), 32'd6);
                runB = 0;
            end
            if (stA[16] & stA[14] & stA[10] & stA[2]) initA++;
            if (stB[16] & stB[14] & stB[10] & stB[2]) initB++;
            if (stB[6] === 1'b1 && selB == 2'b01)
                check("B fi at LD_FILT", 32'(fiB), 32'(initB - 1));
            if (doneA === 1'b1) begin
                check("A inits per run", 32'(initA), 32'd1);
                initA = 0;
                doneCntA++;
            end
            if (doneB === 1'b1) begin
                check("B inits per run", 32'(initB), 32'd3);
                initB = 0;
                doneCntB++;
            end

            // drive stimulus for the next edge
            if (cyc > 1) begin
                rst = 0;
                if (!didRst && mB == CALC && fiMB == 2) begin
                    rst = 1;
                    didRst = 1;
                end else if ($urandom_range(0, 299) == 0 &&
                             !inMem(mA) && !inMem(mB)) begin
                    rst = 1;
                end
            end
            start      = (cyc < 800) ? 1'b1 : ($urandom_range(0, 3) == 0);
            adr_ready  = 1'($urandom_range(0, 1));
            filt_full  = 1'($urandom_range(0, 1));
            temp_full  = 1'($urandom_range(0, 1));
            temp_empty = ($urandom_range(0, 2) == 0);
            calc_done  = 1'($urandom_range(0, 1));
            wr_full    = ($urandom_range(0, 2) == 0);
            adr_last   = ($urandom_range(0, 3) == 0);
            if (inMem(mB)) begin
                mem_ack = (ackWait == 5);
                ackWait++;
            end else begin
                ackWait = 0;
                mem_ack = 1'($urandom_range(0, 1));
            end

            if (rst) begin
                mA = IDLE; mB = IDLE; fiMA = 0; fiMB = 0;
                initA = 0; initB = 0; runA = 0; runB = 0;
            end else begin
                stT nA, nB;
                nA = nextSt(mA, fiMA == 0, 1'b0);
                nB = nextSt(mB, fiMB == 2, 1'b1);
                if (mA == DONE) fiMA = 0;
                if (mB == DONE) fiMB = 0;
                else if (mB == NEXT_FILT && fiMB < 2) fiMB++;
                mA = nA;
                mB = nB;
            end
            e.o = expOut(mA); e.fi = fiMA; qA.push_back(e);
            e.o = expOut(mB); e.fi = fiMB; qB.push_back(e);
        end

        check("A runs completed", 32'(doneCntA > 3), 32'd1);
        check("B runs completed", 32'(doneCntB > 1), 32'd1);
        check("reset in CALC hit", 32'(didRst), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
